// File: rtl/div_seq_pkg.sv
// div_seq_pkg
// Shared definitions for the sequential restoring divider:
//   - state encoding (IDLE, RUN, FIX) as plain localparam constants
//   - the quotient value reported for a divide by zero (all ones)
//   - abs_val(): two's-complement magnitude of an operand
// The helper works on a MAX_W-bit container so one function serves
// every WIDTH up to MAX_W; callers zero-extend and truncate around it.
package div_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t FIX  = 2'd2;

  localparam int MAX_W = 64;

  localparam logic [MAX_W-1:0] DIV_ZERO_Q = '1;

  // Negating the zero-extended value and keeping the low 'width' bits
  // gives the same result as a width-bit two's-complement negation.
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] value,
                                               input int               width,
                                               input logic             signed_flag);
    if (signed_flag && value[width-1])
      return -value;
    else
      return value;
  endfunction

endpackage

// File: rtl/div_lzc.sv
// div_lzc
// Parametrised leading-zero counter used by the early-termination build
// of div_seq.
// Ports:
//   value  in   WIDTH  operand to scan
//   count  out  CNT_W  number of leading zeros (WIDTH when value is 0)
module div_lzc
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CNT_W-1:0] count
);

  // Scan from the LSB upward; the highest set bit is the last to write,
  // so it decides the final count.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i])
        count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/div_seq.sv
// div_seq
// Parametrised sequential restoring divider, signed or unsigned, with a
// start/busy/done handshake. Remainder goes to HI, quotient to LO.
// Ports:
//   clock      in   1      rising-edge clock
//   reset      in   1      synchronous, active-high
//   start      in   1      request, sampled only while idle
//   is_signed  in   1      1 = two's-complement operands
//   dividend   in   WIDTH  sampled with start
//   divisor    in   WIDTH  sampled with start
//   busy       out  1      high during RUN and FIX
//   done       out  1      one-cycle completion pulse
//   div_zero   out  1      last completed operation divided by zero
//   quotient   out  WIDTH  LO result
//   remainder  out  WIDTH  HI result
// Optional build macro DIV_SEQ_EARLY_EN: skip the dividend's leading
// zeros by pre-shifting at accept, shortening the iteration count.
// Results are identical with or without it. WIDTH must be 4..64.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] dvs_mag;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] dvd_mag_in;
  logic [WIDTH-1:0] dvs_mag_in;
  logic [WIDTH-1:0] load_q;
  logic [CNT_W-1:0] load_cnt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;

  // Operand magnitudes presented to the datapath at accept time.
  always_comb begin
    dvd_mag_in = WIDTH'(abs_val(MAX_W'(dividend), WIDTH, is_signed));
    dvs_mag_in = WIDTH'(abs_val(MAX_W'(divisor), WIDTH, is_signed));
  end

`ifdef DIV_SEQ_EARLY_EN
  logic [CNT_W-1:0] lz_count;

  div_lzc #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_lzc (
    .value(dvd_mag_in),
    .count(lz_count)
  );

  // Leading zeros would only shift zero quotient bits in, so drop them up
  // front. A zero dividend yields a zero count and goes straight to FIX.
  always_comb begin
    load_q   = dvd_mag_in << lz_count;
    load_cnt = CNT_W'(WIDTH) - lz_count;
  end
`else
  // Fixed-latency build: always iterate over every dividend bit.
  always_comb begin
    load_q   = dvd_mag_in;
    load_cnt = CNT_W'(WIDTH);
  end
`endif

  // One restoring step: bring in the next dividend bit and try to
  // subtract. The partial remainder stays below the divisor, so a borrow
  // shows up exactly in bit WIDTH of the trial difference.
  always_comb begin
    shifted = {rem_r[WIDTH-2:0], q_r[WIDTH-1]};
    trial   = {rem_r, q_r[WIDTH-1]} - {1'b0, dvs_mag};
  end

  assign busy = (state != IDLE);

  // Control FSM and datapath registers. done defaults low so it pulses
  // for a single cycle; results hold until the next accepted start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_r     <= '0;
      q_r       <= '0;
      dvs_mag   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient  <= WIDTH'(DIV_ZERO_Q);
              remainder <= dividend;
              div_zero  <= 1'b1;
              done      <= 1'b1;
            end else begin
              neg_q    <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              neg_r    <= is_signed & dividend[WIDTH-1];
              q_r      <= load_q;
              rem_r    <= '0;
              dvs_mag  <= dvs_mag_in;
              cnt      <= load_cnt;
              div_zero <= 1'b0;
              state    <= (load_cnt == '0) ? FIX : RUN;
            end
          end
        end
        RUN: begin
          if (trial[WIDTH]) begin
            rem_r <= shifted;
            q_r   <= {q_r[WIDTH-2:0], 1'b0};
          end else begin
            rem_r <= trial[WIDTH-1:0];
            q_r   <= {q_r[WIDTH-2:0], 1'b1};
          end
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1))
            state <= FIX;
        end
        FIX: begin
          quotient  <= neg_q ? -q_r : q_r;
          remainder <= neg_r ? -rem_r : rem_r;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq
// Directed bench for div_seq at WIDTH=32 with hand-computed results.
// Expected latencies are given for both the fixed build and the
// DIV_SEQ_EARLY_EN build; the matching one is chosen at compile time.
module tb_div_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int vectors   = 0;
  int fails     = 0;
  int lat_cnt   = 0;
  int busy_cnt  = 0;

  div_seq #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .is_signed(is_signed),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .div_zero(div_zero),
    .quotient(quotient),
    .remainder(remainder)
  );

  // Free-running 10-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single compare point: counts every comparison and every failure.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 unit later, tallying busy cycles.
  task automatic tick();
    if (busy === 1'b1) busy_cnt++;
    @(posedge clock);
    #1;
    lat_cnt++;
  endtask

  // Present one request and let the accepting edge E0 pass.
  task automatic applyStimulus(input logic s, input logic [31:0] dvd, input logic [31:0] dvs);
    start     = 1'b1;
    is_signed = s;
    dividend  = dvd;
    divisor   = dvs;
    @(posedge clock);
    #1;
    start    = 1'b0;
    lat_cnt  = 0;
    busy_cnt = 0;
    if (dvs != 32'd0) chk("done_low_after_accept", {31'd0, done}, 32'd0);
  endtask

  // Wait (bounded) for done.
  task automatic waitDone();
    while (done !== 1'b1 && lat_cnt < 200) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] exp_q, input logic [31:0] exp_r,
                             input logic exp_dz, input int lat_fixed, input int lat_early,
                             input logic chk_busy);
    int exp_lat;
`ifdef DIV_SEQ_EARLY_EN
    exp_lat = lat_early;
`else
    exp_lat = lat_fixed;
`endif
    waitDone();
    $display("[TB] %s: quotient=%h remainder=%h latency=%0d", tag, quotient, remainder, lat_cnt);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_quotient"}, quotient, exp_q);
    chk({tag, "_remainder"}, remainder, exp_r);
    chk({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, exp_dz});
    chk({tag, "_latency"}, lat_cnt, exp_lat);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    if (chk_busy) chk({tag, "_busy_cycles"}, busy_cnt, exp_lat);
  endtask

  task automatic checkReset(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_div_zero"}, {31'd0, div_zero}, 32'd0);
    chk({tag, "_quotient"}, quotient, 32'd0);
    chk({tag, "_remainder"}, remainder, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    tick();
    tick();
    checkReset("reset");
    reset = 1'b0;
    tick();

    // Basic unsigned division.
    applyStimulus(1'b0, 32'd100, 32'd7);
    checkOutput("u100_7", 32'd14, 32'd2, 1'b0, 33, 8, 1'b1);

    // Signed cases: quotient truncates toward zero, remainder follows dividend.
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);
    checkOutput("s-7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 4, 1'b1);
    applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE);
    checkOutput("s7_-2", 32'hFFFF_FFFD, 32'd1, 1'b0, 33, 4, 1'b1);

    // Signed overflow and unsigned all-ones.
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("s_ovf", 32'h8000_0000, 32'd0, 1'b0, 33, 33, 1'b1);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1);
    checkOutput("u_max_1", 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 33, 1'b1);

    // Divide by zero: immediate done, busy never asserts.
    applyStimulus(1'b0, 32'd5, 32'd0);
    checkOutput("div0", 32'hFFFF_FFFF, 32'd5, 1'b1, 0, 0, 1'b1);

    // Next normal op clears div_zero (back-to-back with the done cycle).
    applyStimulus(1'b0, 32'd1000, 32'd10);
    checkOutput("u1000_10", 32'd100, 32'd0, 1'b0, 33, 11, 1'b1);

    // A start pulse at E10 while busy must be ignored.
    applyStimulus(1'b0, 32'd1000, 32'd3);
    for (int i = 0; i < 9; i++) tick();
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    tick();
    start = 1'b0;
    checkOutput("ignored_start", 32'd333, 32'd1, 1'b0, 33, 11, 1'b0);
    tick();
    chk("no_queued_op_busy", {31'd0, busy}, 32'd0);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("result_hold", quotient, 32'd333);

    // Reset at E15 aborts the in-flight operation.
    applyStimulus(1'b0, 32'hFFFF_0000, 32'd3);
    for (int i = 0; i < 14; i++) tick();
    reset = 1'b1;
    tick();
    checkReset("mid_reset");
    reset = 1'b0;
    tick();
    chk("mid_reset_stays_idle", {31'd0, busy}, 32'd0);

    // Fresh signed op after the abort.
    applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7);
    checkOutput("s-100_7", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33, 8, 1'b1);

    // Short dividends: early-termination boundary cases.
    applyStimulus(1'b0, 32'd3, 32'd1);
    checkOutput("u3_1", 32'd3, 32'd0, 1'b0, 33, 3, 1'b1);
    applyStimulus(1'b0, 32'd0, 32'd9);
    checkOutput("u0_9", 32'd0, 32'd0, 1'b0, 33, 1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
